// File: rtl/apb_mgr_subsystem_pkg.sv
// Shared types and address map for the APB manager subsystem.
// Four peripherals, each owning one 4 KiB page starting at 0x1000_0000.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    localparam int unsigned APB_NSLV = 4;

    localparam logic [31:0] APB_BASE0 = 32'h1000_0000;
    localparam logic [31:0] APB_BASE1 = 32'h1000_1000;
    localparam logic [31:0] APB_BASE2 = 32'h1000_2000;
    localparam logic [31:0] APB_BASE3 = 32'h1000_3000;

    localparam logic [31:0] APB_PAGE_MASK = 32'hFFFF_F000;

    function automatic logic [31:0] apb_base(input int unsigned idx);
        case (idx)
            0:       return APB_BASE0;
            1:       return APB_BASE1;
            2:       return APB_BASE2;
            default: return APB_BASE3;
        endcase
    endfunction

endpackage

// File: rtl/apb_mgr_subsystem_if.sv
// Requester-side bus of the APB manager subsystem.
// The APB outputs are also carried so the requester can observe the transaction.
interface apb_mgr_subsystem_if;
    import apb_pkg::*;

    logic                transfer;
    logic                write;
    logic [31:0]         addr;
    logic [31:0]         wdata;
    logic [31:0]         rdata;
    logic                ready;
    logic [3:0]          paddr;
    logic                pwrite;
    logic                penable;
    logic [31:0]         pwdata;
    logic [APB_NSLV-1:0] psel;

    modport master (
        output transfer, write, addr, wdata,
        input  rdata, ready, paddr, pwrite, penable, pwdata, psel
    );

    modport slave (
        input  transfer, write, addr, wdata,
        output rdata, ready, paddr, pwrite, penable, pwdata, psel
    );

endinterface

// File: rtl/APB_Manager.sv
// APB3 manager: converts a one-cycle transfer strobe into a SETUP/ACCESS sequence
// and returns the selected peripheral's read data with a ready pulse.
module APB_Manager
    import apb_pkg::*;
(
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [3:0]  PADDR,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic [31:0] PWDATA,
    output logic        PSEL0,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PSEL3,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3
);

    apb_state_e          state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                write_q, write_d;
    logic [APB_NSLV-1:0] sel, pready_vec, psel_vec;
    logic                hit, sel_ready, latch;
    logic [31:0]         sel_rdata;

    apb_addr_decoder u_dec (
        .addr (addr_q),
        .sel  (sel),
        .hit  (hit)
    );

    assign pready_vec = {PREADY3, PREADY2, PREADY1, PREADY0};

    always_comb begin
        sel_rdata = ({32{sel[0]}} & PRDATA0) | ({32{sel[1]}} & PRDATA1) |
                    ({32{sel[2]}} & PRDATA2) | ({32{sel[3]}} & PRDATA3);
        // Unmapped accesses complete at once so the requester never stalls.
        sel_ready = hit ? |(sel & pready_vec) : 1'b1;
        ready     = (state_q == ACCESS) && sel_ready;
        rdata     = ready ? sel_rdata : '0;
        psel_vec  = (state_q == IDLE) ? '0 : sel;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    latch   = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (sel_ready) begin
                    latch   = transfer;
                    state_d = transfer ? SETUP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (latch) begin
            addr_d  = addr;
            wdata_d = wdata;
            write_d = write;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    assign PADDR   = addr_q[3:0];
    assign PWRITE  = write_q;
    assign PWDATA  = wdata_q;
    assign PENABLE = state_q == ACCESS;
    assign PSEL0   = psel_vec[0];
    assign PSEL1   = psel_vec[1];
    assign PSEL2   = psel_vec[2];
    assign PSEL3   = psel_vec[3];

endmodule

// File: rtl/APB_slave.sv
// Zero-wait-state APB peripheral holding four 32-bit registers.
module APB_slave (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [3:0]  PADDR,
    input  logic        PWRITE,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY
);

    logic [31:0] regs_q [4];
    logic [31:0] regs_d [4];
    logic        access;
    logic        unused_paddr;

    // Registers are word-indexed; byte offset bits carry no meaning.
    assign unused_paddr = ^PADDR[1:0];
    assign access       = PSEL & PENABLE;
    assign PREADY       = access;
    assign PRDATA       = (access && !PWRITE) ? regs_q[PADDR[3:2]] : '0;

    always_comb begin
        regs_d = regs_q;
        if (access && PWRITE) begin
            regs_d[PADDR[3:2]] = PWDATA;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/apb_addr_decoder.sv
// Maps a 32-bit address onto a one-hot peripheral select.
// hit is low when the address falls outside every peripheral page.
module apb_addr_decoder
    import apb_pkg::*;
(
    input  logic [31:0]         addr,
    output logic [APB_NSLV-1:0] sel,
    output logic                hit
);

    always_comb begin
        sel = '0;
        for (int i = 0; i < APB_NSLV; i++) begin
            sel[i] = (addr & APB_PAGE_MASK) == apb_base(i);
        end
    end

    assign hit = |sel;

endmodule

// File: rtl/apb_mgr_subsystem.sv
// APB manager with its four register-file peripherals attached.
module apb_mgr_subsystem
    import apb_pkg::*;
(
    input  logic                PCLK,
    input  logic                PRESET,
    apb_mgr_subsystem_if.slave  bus
);

    logic [APB_NSLV-1:0] psel;
    logic [APB_NSLV-1:0] pready;
    logic [31:0]         prdata [APB_NSLV];

    APB_Manager u_mgr (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer (bus.transfer),
        .write    (bus.write),
        .addr     (bus.addr),
        .wdata    (bus.wdata),
        .rdata    (bus.rdata),
        .ready    (bus.ready),
        .PADDR    (bus.paddr),
        .PWRITE   (bus.pwrite),
        .PENABLE  (bus.penable),
        .PWDATA   (bus.pwdata),
        .PSEL0    (psel[0]),
        .PSEL1    (psel[1]),
        .PSEL2    (psel[2]),
        .PSEL3    (psel[3]),
        .PRDATA0  (prdata[0]),
        .PRDATA1  (prdata[1]),
        .PRDATA2  (prdata[2]),
        .PRDATA3  (prdata[3]),
        .PREADY0  (pready[0]),
        .PREADY1  (pready[1]),
        .PREADY2  (pready[2]),
        .PREADY3  (pready[3])
    );

    for (genvar i = 0; i < APB_NSLV; i++) begin : g_slv
        APB_slave u_slv (
            .PCLK    (PCLK),
            .PRESET  (PRESET),
            .PADDR   (bus.paddr),
            .PWRITE  (bus.pwrite),
            .PSEL    (psel[i]),
            .PENABLE (bus.penable),
            .PWDATA  (bus.pwdata),
            .PRDATA  (prdata[i]),
            .PREADY  (pready[i])
        );
    end

    assign bus.psel = psel;

endmodule

// File: tb/tb_apb_mgr_subsystem.sv
// Directed bench for apb_mgr_subsystem with a scoreboard of expected read data.
module tb_apb_mgr_subsystem;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    apb_mgr_subsystem_if m ();

    apb_mgr_subsystem dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (m)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    logic        cur_wr;
    logic [31:0] cur_addr;
    logic [31:0] cur_wd;

    function automatic logic [3:0] sel_of(input logic [31:0] a);
        case (a[31:12])
            20'h10000: return 4'b0001;
            20'h10001: return 4'b0010;
            20'h10002: return 4'b0100;
            20'h10003: return 4'b1000;
            default:   return 4'b0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request at the current time; the scoreboard gets the data expected at ready.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd);
        m.transfer = 1'b1;
        m.write    = wr;
        m.addr     = a;
        m.wdata    = wd;
        cur_wr     = wr;
        cur_addr   = a;
        cur_wd     = wd;
        exp_q.push_back(wr ? 32'h0 : exp_rd);
    endtask

    // Walk the issued request through SETUP and ACCESS; returns in the ready cycle.
    task automatic follow();
        int          cyc;
        logic [31:0] exp_rd;
        @(negedge clk);
        m.transfer = 1'b0;
        chk("setup_psel", 32'(m.psel), 32'(sel_of(cur_addr)));
        chk("setup_penable", 32'(m.penable), 32'd0);
        chk("setup_ready", 32'(m.ready), 32'd0);
        chk("setup_paddr", 32'(m.paddr), 32'(cur_addr[3:0]));
        @(negedge clk);
        cyc = 0;
        while (m.ready !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        chk("ready_latency", cyc, 32'd0);
        chk("access_ready", 32'(m.ready), 32'd1);
        chk("access_penable", 32'(m.penable), 32'd1);
        chk("access_psel", 32'(m.psel), 32'(sel_of(cur_addr)));
        chk("access_pwrite", 32'(m.pwrite), 32'(cur_wr));
        chk("access_pwdata", m.pwdata, cur_wd);
        exp_rd = exp_q.pop_front();
        chk("rdata", m.rdata, exp_rd);
    endtask

    task automatic run(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd);
        @(negedge clk);
        issue(wr, a, wd, exp_rd);
        follow();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        m.transfer = 1'b0;
        m.write    = 1'b0;
        m.addr     = '0;
        m.wdata    = '0;
        @(negedge clk);
        chk("rst_psel", 32'(m.psel), 32'd0);
        chk("rst_penable", 32'(m.penable), 32'd0);
        chk("rst_ready", 32'(m.ready), 32'd0);
        chk("rst_rdata", m.rdata, 32'd0);
        chk("rst_paddr", 32'(m.paddr), 32'd0);
        chk("rst_pwrite", 32'(m.pwrite), 32'd0);
        chk("rst_pwdata", m.pwdata, 32'd0);
        rst = 1'b0;

        run(1'b0, 32'h1000_0000, 32'h0, 32'h0);
        run(1'b0, 32'h1000_1000, 32'h0, 32'h0);
        run(1'b0, 32'h1000_2000, 32'h0, 32'h0);
        run(1'b0, 32'h1000_300C, 32'h0, 32'h0);

        run(1'b1, 32'h1000_0000, 32'h1234_5678, 32'h0);
        run(1'b1, 32'h1000_1000, 32'hDEAD_BEEF, 32'h0);
        run(1'b1, 32'h1000_2000, 32'hCAFE_BABE, 32'h0);
        run(1'b1, 32'h1000_3000, 32'h8765_4321, 32'h0);

        run(1'b0, 32'h1000_0000, 32'h0, 32'h1234_5678);
        run(1'b0, 32'h1000_1000, 32'h0, 32'hDEAD_BEEF);
        run(1'b0, 32'h1000_2000, 32'h0, 32'hCAFE_BABE);
        run(1'b0, 32'h1000_3000, 32'h0, 32'h8765_4321);

        run(1'b1, 32'h1000_1008, 32'hA5A5_A5A5, 32'h0);
        run(1'b0, 32'h1000_1008, 32'h0, 32'hA5A5_A5A5);
        run(1'b0, 32'h1000_1000, 32'h0, 32'hDEAD_BEEF);

        run(1'b0, 32'h2000_0000, 32'h0, 32'h0);
        run(1'b1, 32'h2000_3000, 32'hFFFF_FFFF, 32'h0);
        run(1'b0, 32'h1000_3000, 32'h0, 32'h8765_4321);

        // Chain three requests with transfer held in each ready cycle.
        run(1'b0, 32'h1000_0000, 32'h0, 32'h1234_5678);
        issue(1'b1, 32'h1000_3004, 32'h0BAD_F00D, 32'h0);
        follow();
        issue(1'b0, 32'h1000_3004, 32'h0, 32'h0BAD_F00D);
        follow();
        run(1'b0, 32'h1000_3000, 32'h0, 32'h8765_4321);

        // Reset during ACCESS of a write must abort it before the register commits.
        @(negedge clk);
        m.transfer = 1'b1;
        m.write    = 1'b1;
        m.addr     = 32'h1000_2000;
        m.wdata    = 32'hFFFF_0000;
        @(negedge clk);
        m.transfer = 1'b0;
        @(negedge clk);
        chk("abort_access_ready", 32'(m.ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_psel", 32'(m.psel), 32'd0);
        chk("abort_penable", 32'(m.penable), 32'd0);
        chk("abort_ready", 32'(m.ready), 32'd0);
        rst = 1'b0;
        run(1'b0, 32'h1000_2000, 32'h0, 32'h0);
        run(1'b0, 32'h1000_1008, 32'h0, 32'h0);

        @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
